// File: rtl/fpu_sched_pkg.sv
// Shared types and the round-robin pick helper for the fadd issue arbiter.
package fpu_sched_pkg;

    localparam int ID_W = 2;

    typedef logic [4:0] fadd_tag_t;

    typedef struct packed {
        logic [31:0]     y;
        logic            flag;
        fadd_tag_t       add;
        logic [ID_W-1:0] id;
    } res_entry_t;

    // Returns {hit, index}: first set bit of valid at or after ptr, modulo nreq.
    function automatic logic [ID_W:0] rr_pick(input logic [3:0] valid,
                                              input logic [ID_W-1:0] ptr,
                                              input int nreq);
        logic [ID_W:0]   pick;
        logic [ID_W-1:0] sel;
        int              idx;
        pick = '0;
        for (int k = 3; k >= 0; k--) begin
            idx = (int'(ptr) + k) % nreq;
            sel = idx[ID_W-1:0];
            if (k < nreq && valid[sel]) begin
                pick = {1'b1, sel};
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/fadd_res_fifo.sv
// Result FIFO between the fadd capture point and writeback; head is readable
// in the cycle after the push so results reach writeback with minimum latency.
module fadd_res_fifo
    import fpu_sched_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  res_entry_t       i_data,
    input  logic             i_pop,
    output res_entry_t       o_head,
    output logic             o_valid,
    output logic [CNT_W-1:0] o_count
);

    res_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_pop   = i_pop && (r_count != '0);
    assign o_valid = (r_count != '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Issue credit must make an overflowing push impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(i_push && r_count == CNT_W'(DEPTH)));

endmodule

// File: rtl/fadd_issue_arbiter.sv
// Round-robin, credit-gated issue of NREQ requesters into one pipelined fadd,
// with id/tag tracking alongside the pipe and an in-order result FIFO.
module fadd_issue_arbiter
    import fpu_sched_pkg::*;
#(
    parameter  int NSTAGE     = 2,
    parameter  int NREQ       = 2,
    parameter  int FIFO_DEPTH = 4,
    localparam int IDW        = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ-1:0][31:0] req_x1,
    input  logic [NREQ-1:0][31:0] req_x2,
    input  logic [NREQ-1:0]       req_flag,
    input  logic [NREQ-1:0][4:0]  req_add,
    output logic [31:0]           fa_x1,
    output logic [31:0]           fa_x2,
    output logic                  fa_flagin,
    output logic [4:0]            fa_addin,
    input  logic [31:0]           fa_y,
    input  logic                  fa_flagout,
    input  logic [4:0]            fa_addout,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [31:0]           res_y,
    output logic                  res_flag,
    output logic [4:0]            res_add,
    output logic [IDW-1:0]        res_id,
    output logic                  busy,
    output logic                  err_tag
);

    logic             r_vld_sr  [1:NSTAGE];
    logic [ID_W-1:0]  r_id_sr   [1:NSTAGE];
    fadd_tag_t        r_tag_sr  [1:NSTAGE];
    logic             r_flag_sr [1:NSTAGE];
    logic [ID_W-1:0]  r_rr_ptr;
    logic             r_err_tag;

    logic [ID_W:0]    w_pick;
    logic [ID_W-1:0]  w_win;
    logic [IDW-1:0]   w_win_i;
    logic             w_credit_ok;
    logic             w_grant;
    logic             w_any_vld;
    logic [CNT_W-1:0] w_fifo_cnt;
    logic             w_push;
    logic             w_fifo_valid;
    res_entry_t       w_push_data;
    res_entry_t       w_head;

    // Every op issued and not yet popped holds one FIFO slot in reserve.
    always_comb begin
        int inflight;
        inflight  = 0;
        w_any_vld = 1'b0;
        for (int k = 1; k <= NSTAGE; k++) begin
            inflight  = inflight + int'(r_vld_sr[k]);
            w_any_vld = w_any_vld | r_vld_sr[k];
        end
        w_credit_ok = (inflight + int'(w_fifo_cnt)) < FIFO_DEPTH;
    end

    assign w_pick    = rr_pick(4'(req_valid), r_rr_ptr, NREQ);
    assign w_win     = w_pick[ID_W-1:0];
    assign w_win_i   = w_win[IDW-1:0];
    assign w_grant   = w_credit_ok && w_pick[ID_W];

    assign req_ready = w_grant ? (NREQ'(1) << w_win) : '0;
    assign fa_x1     = w_grant ? req_x1[w_win_i] : '0;
    assign fa_x2     = w_grant ? req_x2[w_win_i] : '0;
    assign fa_flagin = w_grant ? req_flag[w_win_i] : 1'b0;
    assign fa_addin  = w_grant ? req_add[w_win_i] : '0;

    for (genvar gi = 1; gi <= NSTAGE; gi++) begin : g_stage
        always_ff @(posedge clk) begin
            if (rst) begin
                r_vld_sr[gi]  <= 1'b0;
                r_id_sr[gi]   <= '0;
                r_tag_sr[gi]  <= '0;
                r_flag_sr[gi] <= 1'b0;
            end else if (gi == 1) begin
                r_vld_sr[gi]  <= w_grant;
                r_id_sr[gi]   <= w_win;
                r_tag_sr[gi]  <= req_add[w_win_i];
                r_flag_sr[gi] <= req_flag[w_win_i];
            end else begin
                r_vld_sr[gi]  <= r_vld_sr[gi-1];
                r_id_sr[gi]   <= r_id_sr[gi-1];
                r_tag_sr[gi]  <= r_tag_sr[gi-1];
                r_flag_sr[gi] <= r_flag_sr[gi-1];
            end
        end
    end

    assign w_push      = r_vld_sr[NSTAGE];
    assign w_push_data = '{y: fa_y, flag: fa_flagout, add: fa_addout, id: r_id_sr[NSTAGE]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr  <= '0;
            r_err_tag <= 1'b0;
        end else begin
            if (w_grant) begin
                r_rr_ptr <= (int'(w_win) == NREQ - 1) ? '0 : w_win + 1'b1;
            end
            if (w_push && (fa_addout != r_tag_sr[NSTAGE] || fa_flagout != r_flag_sr[NSTAGE])) begin
                r_err_tag <= 1'b1;
            end
        end
    end

    fadd_res_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (res_ready),
        .o_head  (w_head),
        .o_valid (w_fifo_valid),
        .o_count (w_fifo_cnt)
    );

    assign res_valid = w_fifo_valid;
    assign res_y     = w_head.y;
    assign res_flag  = w_head.flag;
    assign res_add   = w_head.add;
    assign res_id    = w_head.id[IDW-1:0];
    assign busy      = w_any_vld || (w_fifo_cnt != '0);
    assign err_tag   = r_err_tag;

endmodule

// File: tb/tb_fadd_issue_arbiter.sv
// Bench for fadd_issue_arbiter with a behavioural 2-stage fadd and a queue-based
// transaction model; directed phases plus a short randomized run.
module tb_fadd_issue_arbiter;

    localparam int NREQ   = 2;
    localparam int NSTAGE = 2;
    localparam int DEPTH  = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0][31:0] req_x1;
    logic [NREQ-1:0][31:0] req_x2;
    logic [NREQ-1:0]       req_flag;
    logic [NREQ-1:0][4:0]  req_add;
    logic [31:0]           fa_x1, fa_x2, fa_y;
    logic                  fa_flagin, fa_flagout;
    logic [4:0]            fa_addin, fa_addout;
    logic                  res_valid, res_ready, res_flag, busy, err_tag;
    logic [31:0]           res_y;
    logic [4:0]            res_add;
    logic [0:0]            res_id;

    int n_pass = 0;
    int n_chk  = 0;
    int corrupt_at = -1;
    bit verbose = 1'b1;
    bit m_on = 1'b0;

    always #5 clk = ~clk;

    fadd_issue_arbiter #(.NSTAGE(NSTAGE), .NREQ(NREQ), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x1(req_x1), .req_x2(req_x2), .req_flag(req_flag), .req_add(req_add),
        .fa_x1(fa_x1), .fa_x2(fa_x2), .fa_flagin(fa_flagin), .fa_addin(fa_addin),
        .fa_y(fa_y), .fa_flagout(fa_flagout), .fa_addout(fa_addout),
        .res_valid(res_valid), .res_ready(res_ready), .res_y(res_y),
        .res_flag(res_flag), .res_add(res_add), .res_id(res_id),
        .busy(busy), .err_tag(err_tag)
    );

    // IEEE single <-> real, denormals flushed to zero.
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0) return 0.0;
        d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        int e;
        d = $realtobits(r);
        e = int'(d[62:52]) - 896;
        if (d[62:52] == 11'd0 || e <= 0) return {d[63], 31'd0};
        if (e >= 255) return {d[63], 8'hFF, 23'd0};
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] rnd_f();
        return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 23'($urandom)};
    endfunction

    // Behavioural fadd: result and sideband appear NSTAGE cycles after the inputs.
    logic [31:0] s1_y, s2_y;
    logic        s1_f, s2_f;
    logic [4:0]  s1_a, s2_a;
    int          fcnt;
    always @(posedge clk) begin
        s1_y <= r2f(f2r(fa_x1) + f2r(fa_x2));
        s1_f <= fa_flagin;
        s1_a <= fa_addin ^ ((|req_ready && fcnt == corrupt_at) ? 5'h10 : 5'h00);
        s2_y <= s1_y;
        s2_f <= s1_f;
        s2_a <= s1_a;
        if (rst) fcnt <= 0;
        else if (|req_ready) fcnt <= fcnt + 1;
    end
    assign fa_y       = s2_y;
    assign fa_flagout = s2_f;
    assign fa_addout  = s2_a;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    // Transaction model: accepted-but-unpopped ops hold credit; results leave in
    // issue order, each visible NSTAGE+1 cycles after its grant.
    typedef struct {
        logic [31:0] y;
        logic        flag;
        logic [4:0]  add;
        int          id;
        longint      rdy;
        bit          bad;
    } exp_t;

    exp_t   q[$];
    int     m_out = 0;
    int     m_ptr = 0;
    int     m_ops = 0;
    bit     m_err = 1'b0;
    longint cyc = 0;

    always @(negedge clk) begin
        int              win;
        int              idx;
        bit              exp_rv;
        bit              yok;
        logic [NREQ-1:0] exp_rdy;
        exp_t            e;
        cyc++;
        win = -1;
        if (m_out < DEPTH) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_ptr + k) % NREQ;
                if (win < 0 && req_valid[idx]) win = idx;
            end
        end
        foreach (q[j]) if (q[j].bad && q[j].rdy <= cyc) m_err = 1'b1;
        exp_rv  = (q.size() > 0) && (q[0].rdy <= cyc);
        exp_rdy = (win >= 0) ? (NREQ'(1) << win) : '0;
        if (!rst && m_on) begin
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("fa_x1", fa_x1, (win >= 0) ? req_x1[win] : 32'd0);
            chk("fa_x2", fa_x2, (win >= 0) ? req_x2[win] : 32'd0);
            chk("fa_flagin", 32'(fa_flagin), (win >= 0) ? 32'(req_flag[win]) : 32'd0);
            chk("fa_addin", 32'(fa_addin), (win >= 0) ? 32'(req_add[win]) : 32'd0);
            chk("res_valid", 32'(res_valid), 32'(exp_rv));
            if (exp_rv) begin
                yok = (res_y === q[0].y) ||
                      (res_y[31] == q[0].y[31] &&
                       ((int'(res_y[30:0]) - int'(q[0].y[30:0])) inside {-1, 1}));
                n_chk++;
                if (yok) n_pass++;
                else $display("FAIL res_y: got %h want %h", res_y, q[0].y);
                chk("res_flag", 32'(res_flag), 32'(q[0].flag));
                chk("res_add", 32'(res_add), 32'(q[0].add));
                chk("res_id", 32'(res_id), 32'(q[0].id));
            end
            chk("busy", 32'(busy), 32'(m_out > 0));
            chk("err_tag", 32'(err_tag), 32'(m_err));
        end
        if (exp_rv && res_ready) begin
            if (verbose) $display("pop: id=%0d add=%0d flag=%0d y=%h", q[0].id, q[0].add, q[0].flag, q[0].y);
            void'(q.pop_front());
            m_out--;
        end
        if (win >= 0) begin
            e.y    = r2f(f2r(req_x1[win]) + f2r(req_x2[win]));
            e.flag = req_flag[win];
            e.bad  = (m_ops == corrupt_at);
            e.add  = req_add[win] ^ (e.bad ? 5'h10 : 5'h00);
            e.id   = win;
            e.rdy  = cyc + NSTAGE + 1;
            q.push_back(e);
            m_out++;
            m_ops++;
            m_ptr = (win + 1) % NREQ;
        end
        if (rst) begin
            q.delete();
            m_out = 0;
            m_ptr = 0;
            m_ops = 0;
            m_err = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] ad, input logic fl);
        req_x1[i]   = a;
        req_x2[i]   = b;
        req_add[i]  = ad;
        req_flag[i] = fl;
    endtask

    task automatic set_rnd(input int i);
        set_op(i, rnd_f(), rnd_f(), 5'($urandom), 1'($urandom));
    endtask

    task automatic drain();
        int n;
        req_valid = '0;
        res_ready = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (!busy) break;
            n++;
            if (n >= 60) begin
                chk("drain_timeout", 32'(n), 32'd0);
                break;
            end
        end
        tick();
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        req_valid = '0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int lat, g, cnt;
        logic [NREQ-1:0] g_prev;
        req_valid = '0;
        res_ready = 1'b1;
        req_x1 = '0; req_x2 = '0; req_flag = '0; req_add = '0;
        repeat (3) tick();
        rst = 1'b0;
        m_on = 1'b1;

        @(negedge clk);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_err_tag", 32'(err_tag), 32'd0);
        tick();

        // Single op: 1.0 + 2.0 from requester 0.
        set_op(0, 32'h3F800000, 32'h40000000, 5'd5, 1'b1);
        req_valid = 2'b01;
        @(negedge clk);
        chk("t1_grant", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        lat = 1;
        while (lat < 10) begin
            @(negedge clk);
            if (res_valid) break;
            tick();
            lat++;
        end
        chk("t1_latency", 32'(lat), 32'd3);
        chk("t1_y", res_y, 32'h40400000);
        chk("t1_add", 32'(res_add), 32'd5);
        chk("t1_flag", 32'(res_flag), 32'd1);
        chk("t1_id", 32'(res_id), 32'd0);
        tick();
        drain();

        // Both requesters always valid; pointer sits at 1 after the single op.
        set_rnd(0);
        set_rnd(1);
        req_valid = 2'b11;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            g = (req_ready == 2'b01) ? 0 : (req_ready == 2'b10) ? 1 : -1;
            chk("t2_alternate", 32'(g), 32'((n + 1) % 2));
            tick();
            if (g >= 0) set_rnd(g);
        end
        drain();

        // Writeback stalled: credit allows exactly DEPTH grants.
        res_ready = 1'b0;
        req_valid = 2'b01;
        cnt = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            g_prev = req_ready;
            if (g_prev[0]) cnt++;
            tick();
            if (g_prev[0]) set_rnd(0);
        end
        chk("t3_grants", 32'(cnt), 32'd4);
        @(negedge clk);
        chk("t3_stalled", 32'(req_ready), 32'd0);
        tick();
        res_ready = 1'b1;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            g_prev = req_ready;
            tick();
            if (g_prev[0]) set_rnd(0);
        end
        drain();

        // Reset with one result queued and two in flight.
        res_ready = 1'b0;
        req_valid = 2'b01;
        for (int n = 0; n < 3; n++) begin
            tick();
            set_rnd(0);
        end
        req_valid = '0;
        rst = 1'b1;
        @(negedge clk);
        chk("t4_queued", 32'(res_valid), 32'd1);
        tick();
        rst = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        chk("t4_res_valid", 32'(res_valid), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);
        tick();
        cnt = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (res_valid) cnt++;
            tick();
        end
        chk("t4_no_stale", 32'(cnt), 32'd0);
        set_rnd(0);
        set_rnd(1);
        req_valid = 2'b11;
        @(negedge clk);
        chk("t4_rr_ptr0", 32'(req_ready), 32'h1);
        tick();
        drain();

        // Third op's tag corrupted inside fadd: err_tag rises at its capture and sticks.
        corrupt_at = 2;
        pulse_rst();
        set_rnd(0);
        req_valid = 2'b01;
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            chk("t5_err_tag", 32'(err_tag), 32'(k >= 5));
            g_prev = req_ready;
            tick();
            if (g_prev[0]) set_rnd(0);
            if (k == 4) req_valid = '0;
        end
        drain();
        corrupt_at = -1;
        pulse_rst();

        // Randomized traffic and backpressure.
        verbose = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            g_prev = req_ready;
            tick();
            res_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (g_prev[i] || !req_valid[i]) begin
                    req_valid[i] = 1'($urandom_range(0, 1));
                    set_rnd(i);
                end
            end
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
